// File: rtl/fb_pixel_writer.sv
// Framebuffer write stage: buffers range-checked pixels in a FIFO and issues
// one single-word SDRAM write per pixel through the controller's wr_*/busy port.
module fb_pixel_writer #(
    parameter int          H_RES      = 800,
    parameter int          V_RES      = 600,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [23:0] FB0_BASE   = 24'h000000,
    parameter logic [23:0] FB1_BASE   = 24'h080000
) (
    input  logic                          clk_in,
    input  logic                          reset_btn,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    input  logic [9:0]                    pix_x,
    input  logic [9:0]                    pix_y,
    input  logic [15:0]                   pix_rgb,
    input  logic                          fb_sel,
    output logic [23:0]                   wr_addr,
    output logic [15:0]                   wr_data,
    output logic                          wr_enable,
    input  logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  count_q, count_d;
    logic [23:0]    wr_addr_q, wr_addr_d;
    logic [15:0]    wr_data_q, wr_data_d;
    logic           last_q, last_d;
    logic           frame_done_q, frame_done_d;
    logic [15:0]    drop_cnt_q, drop_cnt_d;

    // Entry layout: {addr[23:0], rgb[15:0], last}
    logic [40:0]    mem_q [FIFO_DEPTH];
    logic [40:0]    head;

    logic           full, empty, accept, in_range, push, drop, pop, last_in;
    logic [23:0]    pix_addr;

    assign full      = (count_q == LW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign pix_ready = !full;
    assign accept    = pix_valid && pix_ready;
    assign in_range  = (int'(pix_x) < H_RES) && (int'(pix_y) < V_RES);
    assign push      = accept && in_range;
    assign drop      = accept && !in_range;
    assign last_in   = (int'(pix_x) == H_RES - 1) && (int'(pix_y) == V_RES - 1);
    // Constant multiplier folds to shift-and-add in synthesis.
    assign pix_addr  = (fb_sel ? FB1_BASE : FB0_BASE)
                     + 24'(pix_y) * 24'(H_RES) + 24'(pix_x);
    assign head      = mem_q[rd_ptr_q];
    assign pop       = (state_q == S_IDLE) && !empty && !busy;

    assign wr_enable  = (state_q == S_REQ);
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign fifo_level = count_q;
    assign drop_cnt   = drop_cnt_q;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        last_d       = last_q;
        frame_done_d = 1'b0;
        drop_cnt_d   = drop_cnt_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    wr_addr_d = head[40:17];
                    wr_data_d = head[16:1];
                    last_d    = head[0];
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (busy) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!busy) begin
                    state_d      = S_IDLE;
                    frame_done_d = last_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_btn) begin
        if (reset_btn) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            last_q       <= last_d;
            frame_done_q <= frame_done_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr_q] <= {pix_addr, pix_rgb, last_in};
    end

endmodule

// File: doc/fb_pixel_writer.md
# fb_pixel_writer

Framebuffer write stage that sits directly downstream of the renderer's SET_PIXEL pipeline stage. It accepts shaded pixels (x, y, RGB565) on a valid/ready stream and buffers them in a small FIFO. It converts each pixel to a linear SDRAM word address in one of two framebuffers and issues single-word writes to `sdram_controller` through its `wr_*`/`busy` host port. It signals the end of a frame once the last pixel has been committed.

## Interface
Parameters:
- `H_RES`, 800: horizontal resolution in pixels.
- `V_RES`, 600: vertical resolution in pixels.
- `FIFO_DEPTH`, 16: pixel FIFO entries; must be a power of 2, minimum 2.
- `FB0_BASE`, 24'h000000: word base address of framebuffer 0.
- `FB1_BASE`, 24'h080000: word base address of framebuffer 1.

Ports:
- `clk_in`  in  1  system clock (100 MHz).
- `reset_btn`  in  1  reset, asynchronous, active-high.
- `pix_valid`  in  1  pixel offered by the render pipeline.
- `pix_ready`  out  1  FIFO can accept a pixel (= !full).
- `pix_x`  in  10  pixel column.
- `pix_y`  in  10  pixel row.
- `pix_rgb`  in  16  RGB565 colour.
- `fb_sel`  in  1  target framebuffer, sampled with each accepted pixel.
- `wr_addr`  out  24  SDRAM word address to the controller.
- `wr_data`  out  16  SDRAM write data to the controller.
- `wr_enable`  out  1  write request to the controller.
- `busy`  in  1  controller busy.
- `frame_done`  out  1  one-cycle pulse when pixel (H_RES-1, V_RES-1) is committed.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `drop_cnt`  out  16  count of out-of-range pixels discarded; saturates at 16'hFFFF.

## Operation
- A pixel is accepted on a rising edge when `pix_valid && pix_ready`. If `pix_valid` is high while `pix_ready` is low, the pixel is not taken and the source must hold it.
- Range check on accept:
  - A pixel with `pix_x >= H_RES` or `pix_y >= V_RES` is consumed but not stored, and `drop_cnt` increments.
  - This covers the pipeline's end sentinel (800, 600).
- Address on accept: `addr = (fb_sel ? FB1_BASE : FB0_BASE) + pix_y*H_RES + pix_x`, computed in 24 bits with modulo-2^24 wrap.
  - For H_RES=800, `y*800` is `(y<<9)+(y<<8)+(y<<5)`; no hardware multiplier is needed.
- Each FIFO entry stores {addr[23:0], rgb[15:0], last}. `last` = (x == H_RES-1 && y == V_RES-1).
- Write FSM:
  - IDLE: if FIFO non-empty and `busy`=0, pop the head, register `wr_addr`/`wr_data`, go to REQ. Otherwise stay.
  - REQ: `wr_enable`=1. Stay until `busy`=1 is sampled, then go to WAIT with `wr_enable`=0.
  - WAIT: `wr_enable`=0. When `busy`=0 is sampled, go to IDLE. If the popped entry had `last`=1, pulse `frame_done` for exactly one cycle on that edge.
- Push and pop may occur on the same edge. Occupancy is then unchanged. A pixel is never bypassed into REQ without being written to the FIFO first.
- `wr_addr`/`wr_data` hold their last values outside REQ.

## Timing
- Reset values: `pix_ready`=1, `wr_enable`=0, `wr_addr`=0, `wr_data`=0, `frame_done`=0, `fifo_level`=0, `drop_cnt`=0. FSM=IDLE, FIFO pointers=0.
- Reset asserted mid-operation immediately clears the FIFO contents and the FSM. An in-flight REQ is abandoned and `wr_enable` drops asynchronously.
- `pix_ready` is combinational from FIFO full and does not depend on `pix_valid`.
- Latency, with FIFO empty and `busy`=0:
  - Pixel accepted at edge N.
  - Popped at edge N+1.
  - `wr_enable` high in the cycle after N+1.
- One pixel per controller transaction. Throughput is bounded by controller `busy` length plus 2 cycles.
- `fifo_level` and `drop_cnt` update on the same edge as the push, pop or drop.

## Test plan
- Single pixel (x=3, y=2, rgb=16'hF800, fb_sel=0), controller model raising `busy` 1 cycle after `wr_enable` and holding it 5 cycles -> exactly one request with `wr_addr`=24'd1603, `wr_data`=16'hF800; `wr_enable` deasserts the cycle after `busy` is seen; no `frame_done`.
- Last pixel (799, 599, fb_sel=1) -> `wr_addr`=24'h0F52FF; `frame_done` high for exactly one cycle on the edge `busy` falls.
- Backpressure: hold `busy`=1 and offer 20 back-to-back pixels -> 16 accepted; `pix_ready`=0 and `fifo_level`=16 after the 16th. Release `busy` -> all 16 are written in order and the source's held pixel 17 is accepted next.
- Sentinel (800, 600) and (0, 600) -> both consumed without a write; `drop_cnt`=2; `fifo_level` stays 0.
- Full frame 800x600 streamed with random valid gaps and random `busy` lengths -> 480000 writes, each address 0..479999 exactly once, one `frame_done`.
- Assert `reset_btn` while in REQ with 5 entries queued -> `wr_enable`=0 immediately, `fifo_level`=0, `pix_ready`=1. After release, no stale write is issued.
